fb_write_arbiter: RTL and testbench



---
 rtl/fb_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer port-A write arbiter: accepts one pixel stream at a time (mode1 raw or
// mode2 filtered), generates raster addresses and reports frame completion and drops.
module fb_write_arbiter #(
  parameter int unsigned MAX_ROW = 360,
  parameter int unsigned MAX_COL = 540,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        md1_pixel_i,
  input  logic              md1_pixel_en_i,
  input  logic [7:0]        md2_pixel_i,
  input  logic              md2_pixel_en_i,
  input  logic              is_mode1_i,
  input  logic              is_mode2_i,
  input  logic              frame_clr_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [7:0]        dina_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int unsigned ROW_W = $clog2(MAX_ROW);
  localparam int unsigned COL_W = $clog2(MAX_COL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] MD2_START = ADDR_W'(MAX_COL + 1);
  localparam logic [ROW_W-1:0]  ROW_LAST1 = ROW_W'(MAX_ROW - 1);
  localparam logic [COL_W-1:0]  COL_LAST1 = COL_W'(MAX_COL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST2 = ROW_W'(MAX_ROW - 3);
  localparam logic [COL_W-1:0]  COL_LAST2 = COL_W'(MAX_COL - 3);

  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  logic              ena_n, wea_n, done_n, busy_n, drop_inc;
  logic [ADDR_W-1:0] addra_n;
  logic [7:0]        dina_n, drop_n;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      row          <= '0;
      col          <= '0;
      ena_o        <= 1'b0;
      wea_o        <= 1'b0;
      addra_o      <= '0;
      dina_o       <= '0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      row          <= row_n;
      col          <= col_n;
      ena_o        <= ena_n;
      wea_o        <= wea_n;
      addra_o      <= addra_n;
      dina_o       <= dina_n;
      frame_done_o <= done_n;
      busy_o       <= busy_n;
      drop_cnt_o   <= drop_n;
    end
  end

  // Next-state, address generation and write/drop decisions
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    row_n    = row;
    col_n    = col;
    ena_n    = 1'b0;
    wea_n    = 1'b0;
    addra_n  = addra_o;
    dina_n   = dina_o;
    done_n   = 1'b0;
    drop_n   = drop_cnt_o;
    drop_inc = 1'b0;

    case (state)
      IDLE: begin
        if (frame_clr_i) begin
          addr_n = '0;
          row_n  = '0;
          col_n  = '0;
          drop_n = '0;
        end else begin
          drop_inc = md1_pixel_en_i | md2_pixel_en_i;
          if (is_mode1_i) begin
            state_n = MODE1;
            addr_n  = '0;
            row_n   = '0;
            col_n   = '0;
          end else if (is_mode2_i) begin
            state_n = MODE2;
            addr_n  = MD2_START;
            row_n   = '0;
            col_n   = '0;
          end
        end
      end
      MODE1: begin
        if (frame_clr_i || !is_mode1_i) begin
          state_n  = IDLE;
          addr_n   = '0;
          row_n    = '0;
          col_n    = '0;
          if (frame_clr_i) drop_n = '0;
          else             drop_inc = md2_pixel_en_i;
        end else begin
          drop_inc = md2_pixel_en_i;
          if (md1_pixel_en_i) begin
            ena_n   = 1'b1;
            wea_n   = 1'b1;
            addra_n = addr;
            dina_n  = md1_pixel_i;
            if (row == ROW_LAST1 && col == COL_LAST1) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              addr_n = addr + ADDR_W'(1);
              if (col == COL_LAST1) begin
                col_n = '0;
                row_n = row + ROW_W'(1);
              end else begin
                col_n = col + COL_W'(1);
              end
            end
          end
        end
      end
      MODE2: begin
        if (frame_clr_i || !is_mode2_i) begin
          state_n  = IDLE;
          addr_n   = '0;
          row_n    = '0;
          col_n    = '0;
          if (frame_clr_i) drop_n = '0;
          else             drop_inc = md1_pixel_en_i;
        end else begin
          drop_inc = md1_pixel_en_i;
          if (md2_pixel_en_i) begin
            ena_n   = 1'b1;
            wea_n   = 1'b1;
            addra_n = addr;
            dina_n  = md2_pixel_i;
            if (row == ROW_LAST2 && col == COL_LAST2) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else if (col == COL_LAST2) begin
              // Jump over the right border and the next row's left border
              addr_n = addr + ADDR_W'(3);
              col_n  = '0;
              row_n  = row + ROW_W'(1);
            end else begin
              addr_n = addr + ADDR_W'(1);
              col_n  = col + COL_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        if (frame_clr_i) begin
          addr_n = '0;
          row_n  = '0;
          col_n  = '0;
          drop_n = '0;
        end else begin
          drop_inc = md1_pixel_en_i | md2_pixel_en_i;
        end
      end
    endcase

    if (drop_inc && drop_cnt_o != 8'hFF) drop_n = drop_cnt_o + 8'd1;
    busy_n = (state_n == MODE1) || (state_n == MODE2);
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed scoreboard bench for fb_write_arbiter on a 4x5 frame.
module tb_fb_write_arbiter;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    md1_pixel, md2_pixel;
  logic          md1_en, md2_en, is_mode1, is_mode2, frame_clr;
  logic          ena, wea, frame_done, busy;
  logic [AW-1:0] addra;
  logic [7:0]    dina, drop_cnt;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
    logic [31:0]   cyc;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] cyc = '0;
  int          vectors = 0;
  int          miscompares = 0;

  fb_write_arbiter #(.MAX_ROW(4), .MAX_COL(5), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .md1_pixel_i(md1_pixel), .md1_pixel_en_i(md1_en),
    .md2_pixel_i(md2_pixel), .md2_pixel_en_i(md2_en),
    .is_mode1_i(is_mode1), .is_mode2_i(is_mode2), .frame_clr_i(frame_clr),
    .ena_o(ena), .wea_o(wea), .addra_o(addra), .dina_o(dina),
    .frame_done_o(frame_done), .busy_o(busy), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every presented write must match the oldest expected one
  always @(negedge clk) begin
    if (ena) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(addra), 32'(e.addr));
        check("wr_data", 32'(dina), 32'(e.data));
        check("wr_wea", 32'(wea), 32'd1);
        check("wr_done", 32'(frame_done), 32'(e.done));
        check("wr_latency", cyc, e.cyc);
      end
    end else begin
      check("idle_wea", 32'(wea), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put1(input logic [7:0] d, input logic [AW-1:0] a, input logic dn);
    md1_pixel = d;
    md1_en    = 1'b1;
    sb.push_back('{addr: a, data: d, done: dn, cyc: cyc + 32'd1});
    tick();
    md1_en = 1'b0;
  endtask

  task automatic put2(input logic [7:0] d, input logic [AW-1:0] a, input logic dn);
    md2_pixel = d;
    md2_en    = 1'b1;
    sb.push_back('{addr: a, data: d, done: dn, cyc: cyc + 32'd1});
    tick();
    md2_en = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] md2_addr [6];
    md2_addr = '{18'd6, 18'd7, 18'd8, 18'd11, 18'd12, 18'd13};
    rst_n = 1'b0; md1_pixel = '0; md2_pixel = '0; md1_en = 1'b0; md2_en = 1'b0;
    is_mode1 = 1'b0; is_mode2 = 1'b0; frame_clr = 1'b0;
    #3;
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_addr", 32'(addra), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // 1: full mode1 frame
    is_mode1 = 1'b1;
    tick();
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) put1(8'(i), AW'(i), i == 19);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_done", 32'(frame_done), 32'd1);
    is_mode1 = 1'b0;
    tick();
    tick();
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: mode2 interior with border skip
    is_mode2 = 1'b1;
    tick();
    check("t2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) put2(8'hA0 + 8'(i), md2_addr[i], i == 5);
    check("t2_done", 32'(frame_done), 32'd1);
    is_mode2 = 1'b0;
    tick();
    tick();
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: both sources in mode1, then drop saturation in IDLE, then clear
    is_mode1 = 1'b1;
    tick();
    md2_en = 1'b1;
    for (int i = 0; i < 3; i++) put1(8'h30 + 8'(i), AW'(i), 1'b0);
    md2_en = 1'b0;
    check("t3_drop3", 32'(drop_cnt), 32'd3);
    is_mode1 = 1'b0;
    tick();
    md1_en = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    md1_en = 1'b0;
    check("t3_drop_sat", 32'(drop_cnt), 32'd255);
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    check("t3_drop_clr", 32'(drop_cnt), 32'd0);

    // 4: abort coincident with an owner strobe
    is_mode1 = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) put1(8'h40 + 8'(i), AW'(i), 1'b0);
    is_mode1 = 1'b0;
    md1_pixel = 8'hEE;
    md1_en = 1'b1;
    tick();
    md1_en = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_drop", 32'(drop_cnt), 32'd0);
    check("t4_no_write", 32'(ena), 32'd0);
    is_mode1 = 1'b1;
    tick();
    put1(8'h55, AW'(0), 1'b0);
    is_mode1 = 1'b0;
    tick();
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: both mode levels together, mode1 owns
    is_mode1 = 1'b1;
    is_mode2 = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    md2_en = 1'b1;
    tick();
    tick();
    md2_en = 1'b0;
    check("t5_drop", 32'(drop_cnt), 32'd2);
    put1(8'h66, AW'(0), 1'b0);
    is_mode2 = 1'b0;

    // 6: asynchronous reset mid-frame
    put1(8'h67, AW'(1), 1'b0);
    put1(8'h68, AW'(2), 1'b0);
    tick();
    check("t6_pre_addr", 32'(addra), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ena", 32'(ena), 32'd0);
    check("t6_wea", 32'(wea), 32'd0);
    check("t6_addr", 32'(addra), 32'd0);
    check("t6_dina", 32'(dina), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_done", 32'(frame_done), 32'd0);
    is_mode1 = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("t6_post_addr", 32'(addra), 32'd0);
    check("t6_post_busy", 32'(busy), 32'd0);
    md1_en = 1'b1;
    tick();
    md1_en = 1'b0;
    check("t6_idle_drop", 32'(drop_cnt), 32'd1);
    tick();
    tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
